// File: rtl/step_rate_tracker_if.sv
// Bus between the step-total source/display side and step_rate_tracker.
//   start      : run enable (low = pause)
//   stepTotal  : free-running cumulative step count, wraps modulo 2^TOTAL_W
//   ppm        : steps in the last completed second, saturated
//   ppmValid   : ppm holds a real measurement
//   ppmAvg     : floor mean of the last WIN ppm samples
//   avgValid   : a full window of samples has been collected
//   peakPpm    : largest ppm since reset
// master = sample source / consumer side, slave = the tracker.
interface step_rate_tracker_if #(
   parameter int unsigned TOTAL_W = 16
);
   logic               start;
   logic [TOTAL_W-1:0] stepTotal;
   logic [9:0]         ppm;
   logic               ppmValid;
   logic [9:0]         ppmAvg;
   logic               avgValid;
   logic [9:0]         peakPpm;

   modport master (
      output start, stepTotal,
      input  ppm, ppmValid, ppmAvg, avgValid, peakPpm
   );

   modport slave (
      input  start, stepTotal,
      output ppm, ppmValid, ppmAvg, avgValid, peakPpm
   );
endinterface

// File: rtl/step_rate_tracker.sv
// Step-rate tracker: samples a cumulative step total once per secondClk edge
// and produces the per-second rate, a WIN-second moving average and a
// session peak.
//   secondClk : 1 Hz tick, all state updates on its rising edge
//   reset     : synchronous, active-high, clears all state
//   bus       : step_rate_tracker_if slave (start, stepTotal in; rate outputs)
module step_rate_tracker #(
   parameter int unsigned TOTAL_W = 16,
   parameter int unsigned WIN     = 4,
   parameter int unsigned PPM_MAX = 1023
) (
   input  logic               secondClk,
   input  logic               reset,
   step_rate_tracker_if.slave bus
);

   localparam int unsigned PPM_W    = 10;
   localparam int unsigned LOG2_WIN = $clog2(WIN);
   localparam int unsigned PTR_W    = LOG2_WIN;
   localparam int unsigned FILL_W   = LOG2_WIN + 1;
   localparam int unsigned SUM_W    = LOG2_WIN + PPM_W;

   localparam logic [PPM_W-1:0]  PPM_CEIL  = PPM_W'(PPM_MAX);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIN);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] PRIME = 2'd1;
   localparam logic [1:0] RUN   = 2'd2;
   localparam logic [1:0] PAUSE = 2'd3;

   logic [1:0]         state,     stateNext;
   logic [TOTAL_W-1:0] prevTotal, prevTotalNext;
   logic [PPM_W-1:0]   ppmQ,      ppmNext;
   logic               ppmValidQ, ppmValidNext;
   logic [PPM_W-1:0]   ppmAvgQ,   ppmAvgNext;
   logic               avgValidQ, avgValidNext;
   logic [PPM_W-1:0]   peakQ,     peakNext;
   logic [PTR_W-1:0]   wrPtr,     wrPtrNext;
   logic [SUM_W-1:0]   sum,       sumNext;
   logic [FILL_W-1:0]  fillCnt,   fillNext;
   logic [PPM_W-1:0]   hist [WIN];

   logic               takeSample;
   logic [TOTAL_W-1:0] delta;
   logic [PPM_W-1:0]   sample;
   logic [SUM_W-1:0]   sumUpd;
   logic [FILL_W-1:0]  fillUpd;

   // Next-state and datapath update logic.
   always_comb begin
      stateNext     = state;
      prevTotalNext = prevTotal;
      ppmNext       = ppmQ;
      ppmValidNext  = ppmValidQ;
      ppmAvgNext    = ppmAvgQ;
      avgValidNext  = avgValidQ;
      peakNext      = peakQ;
      wrPtrNext     = wrPtr;
      sumNext       = sum;
      fillNext      = fillCnt;
      takeSample    = 1'b0;

      // Modular subtraction absorbs a single wrap of the total.
      delta   = bus.stepTotal - prevTotal;
      sample  = (32'(delta) > PPM_MAX) ? PPM_CEIL : PPM_W'(delta);
      // The slot at wrPtr holds the oldest sample (zero until the window fills).
      sumUpd  = SUM_W'(sum + SUM_W'(sample) - SUM_W'(hist[wrPtr]));
      fillUpd = (fillCnt == FILL_FULL) ? fillCnt : FILL_W'(fillCnt + 1'b1);

      case (state)
         IDLE: begin
            if (bus.start) begin
               prevTotalNext = bus.stepTotal;
               stateNext     = PRIME;
            end
         end
         PRIME, RUN: begin
            if (bus.start) begin
               takeSample = 1'b1;
               stateNext  = RUN;
            end else begin
               stateNext  = PAUSE;
            end
         end
         PAUSE: begin
            // Re-reference so steps taken while paused are never counted.
            if (bus.start) begin
               prevTotalNext = bus.stepTotal;
               stateNext     = PRIME;
            end
         end
         default: stateNext = IDLE;
      endcase

      if (takeSample) begin
         prevTotalNext = bus.stepTotal;
         ppmNext       = sample;
         ppmValidNext  = 1'b1;
         wrPtrNext     = PTR_W'(wrPtr + 1'b1);
         sumNext       = sumUpd;
         fillNext      = fillUpd;
         avgValidNext  = (fillUpd == FILL_FULL);
         ppmAvgNext    = (fillUpd == FILL_FULL) ? PPM_W'(sumUpd >> LOG2_WIN) : '0;
         peakNext      = (sample > peakQ) ? sample : peakQ;
      end
   end

   // State and datapath registers; reset has priority over start.
   always_ff @(posedge secondClk) begin
      if (reset) begin
         state     <= IDLE;
         prevTotal <= '0;
         ppmQ      <= '0;
         ppmValidQ <= 1'b0;
         ppmAvgQ   <= '0;
         avgValidQ <= 1'b0;
         peakQ     <= '0;
         wrPtr     <= '0;
         sum       <= '0;
         fillCnt   <= '0;
         for (int i = 0; i < WIN; i++) hist[i] <= '0;
      end else begin
         state     <= stateNext;
         prevTotal <= prevTotalNext;
         ppmQ      <= ppmNext;
         ppmValidQ <= ppmValidNext;
         ppmAvgQ   <= ppmAvgNext;
         avgValidQ <= avgValidNext;
         peakQ     <= peakNext;
         wrPtr     <= wrPtrNext;
         sum       <= sumNext;
         fillCnt   <= fillNext;
         if (takeSample) hist[wrPtr] <= sample;
      end
   end

   assign bus.ppm      = ppmQ;
   assign bus.ppmValid = ppmValidQ;
   assign bus.ppmAvg   = ppmAvgQ;
   assign bus.avgValid = avgValidQ;
   assign bus.peakPpm  = peakQ;

endmodule

// File: tb/tb_step_rate_tracker.sv
// Testbench for step_rate_tracker: directed scenarios followed by random
// stimulus, checked through an expected-value queue against a sample-list
// reference model.
module tb_step_rate_tracker;

   localparam int unsigned TOTAL_W = 16;
   localparam int unsigned WIN     = 4;
   localparam int unsigned PPM_MAX = 1023;

   typedef struct {
      int  ppm;
      bit  ppmValid;
      int  ppmAvg;
      bit  avgValid;
      int  peakPpm;
   } exp_t;

   logic secondClk;
   logic reset;

   step_rate_tracker_if #(.TOTAL_W(TOTAL_W)) bus ();

   step_rate_tracker #(
      .TOTAL_W(TOTAL_W),
      .WIN    (WIN),
      .PPM_MAX(PPM_MAX)
   ) dut (
      .secondClk(secondClk),
      .reset    (reset),
      .bus      (bus)
   );

   initial secondClk = 1'b0;
   always #5 secondClk = ~secondClk;

   exp_t expQ [$];
   int   checks = 0;
   int   fails  = 0;
   int   pushed = 0;
   int   popped = 0;

   // Reference model: the list of all rate samples since reset, plus whether a
   // reference total is currently held (lost whenever start is low).
   int   samples [$];
   bit   haveRef = 1'b0;
   int   refTotal = 0;

   task automatic modelStep(input bit r, input bit s, input int total);
      int d;
      if (r) begin
         samples.delete();
         haveRef = 1'b0;
      end else if (!s) begin
         haveRef = 1'b0;
      end else if (haveRef) begin
         d = (total - refTotal) & ((1 << TOTAL_W) - 1);
         samples.push_back((d > int'(PPM_MAX)) ? int'(PPM_MAX) : d);
         refTotal = total;
      end else begin
         refTotal = total;
         haveRef  = 1'b1;
      end
   endtask

   function automatic exp_t modelOut();
      exp_t e;
      int   n, acc;
      n = samples.size();
      e.ppm      = (n > 0) ? samples[n-1] : 0;
      e.ppmValid = (n > 0);
      e.avgValid = (n >= int'(WIN));
      acc = 0;
      if (e.avgValid) for (int i = n - int'(WIN); i < n; i++) acc += samples[i];
      e.ppmAvg   = e.avgValid ? acc / int'(WIN) : 0;
      e.peakPpm  = 0;
      foreach (samples[i]) if (samples[i] > e.peakPpm) e.peakPpm = samples[i];
      return e;
   endfunction

   // Drive one second's inputs and queue the outputs expected after the edge.
   task automatic tick(input bit r, input bit s, input int total);
      @(negedge secondClk);
      reset         = r;
      bus.start     = s;
      bus.stepTotal = TOTAL_W'(total);
      modelStep(r, s, total & ((1 << TOTAL_W) - 1));
      expQ.push_back(modelOut());
      pushed++;
   endtask

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: compare every registered output just after each active edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge secondClk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            popped++;
            check("ppm",      int'(bus.ppm),      e.ppm);
            check("ppmValid", int'(bus.ppmValid), int'(e.ppmValid));
            check("ppmAvg",   int'(bus.ppmAvg),   e.ppmAvg);
            check("avgValid", int'(bus.avgValid), int'(e.avgValid));
            check("peakPpm",  int'(bus.peakPpm),  e.peakPpm);
         end
      end
   end

   initial begin
      int t;
      int addList [5];
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.stepTotal = '0;

      tick(1, 0, 0);
      tick(1, 0, 0);

      // First measurement two edges after start; rates 33, 32, 35.
      tick(0, 1, 100);
      tick(0, 1, 133);
      tick(0, 1, 165);
      tick(0, 1, 200);

      // Steady 40 steps per second fills the window.
      t = 200;
      for (int i = 0; i < 5; i++) begin
         t += 40;
         tick(0, 1, t);
      end

      // Window averages 101/4 then 91/4.
      addList = '{10, 20, 30, 41, 0};
      foreach (addList[i]) begin
         t += addList[i];
         tick(0, 1, t);
      end

      // Jump to near the top (saturates), then wrap 0xFFFE -> 0x0003.
      tick(0, 1, 32'hFFFE);
      tick(0, 1, 3);

      // Large jump saturates ppm and peak.
      t = 3 + 2000;
      tick(0, 1, t);

      // Pause three seconds while steps continue, then resume.
      for (int i = 0; i < 3; i++) begin
         t += 100;
         tick(0, 0, t);
      end
      tick(0, 1, t);
      t += 17;
      tick(0, 1, t);
      t += 21;
      tick(0, 1, t);

      // Reset mid-run wins over start.
      tick(1, 1, t);
      tick(0, 0, t);

      // Random phase.
      for (int i = 0; i < 500; i++) begin
         int inc;
         bit r, s;
         r = ($urandom_range(99) == 0);
         s = ($urandom_range(7) != 0);
         if ($urandom_range(19) == 0) inc = int'($urandom_range(5000, 500));
         else                         inc = int'($urandom_range(80));
         t = (t + inc) & ((1 << TOTAL_W) - 1);
         tick(r, s, t);
      end

      @(negedge secondClk);
      @(negedge secondClk);
      check("queueDrained", popped, pushed);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
